// File: rtl/hd_block_ctrl_if.sv
// hd_block_ctrl_if
//   Request / write-stream / read-stream bundle between the CPU disk-I/O unit
//   (master) and the simulated block disk hd_block_ctrl (slave).
//   Parameters:
//     DATA_WIDTH - word width
//     BLOCK_W    - block index width (ADDR_WIDTH - log2(BLOCK_WORDS))
//   Signals:
//     req_valid/req_ready/req_write/req_block - block request handshake
//     wr_data/wr_valid/wr_ready               - write word stream
//     rd_data/rd_valid/rd_last                - read word stream, no backpressure
//     done/err/busy                           - completion / protect / activity status
interface hd_block_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BLOCK_W    = 5
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [BLOCK_W-1:0]    req_block;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  done;
    logic                  err;
    logic                  busy;

    modport master (
        output req_valid, req_write, req_block, wr_data, wr_valid,
        input  req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err, busy
    );

    modport slave (
        input  req_valid, req_write, req_block, wr_data, wr_valid,
        output req_ready, wr_ready, rd_data, rd_valid, rd_last, done, err, busy
    );
endinterface

// File: rtl/hd_block_ctrl.sv
// hd_block_ctrl
//   Simulated hard disk: moves whole blocks of BLOCK_WORDS words between the
//   CPU disk-I/O unit and an internal synchronous-read storage array, after a
//   fixed SEEK_CYCLES seek delay. The array itself is never reset.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - hd_block_ctrl_if.slave (request, write stream, read stream, status)
//   Optional build macro:
//     HD_WRITE_PROTECT_EN - writes to blocks 0..PROTECT_BLOCKS-1 run the full
//                           handshake but leave the array untouched, and raise
//                           err together with done. Undefined: err is 0.
module hd_block_ctrl #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned BLOCK_WORDS    = 16,
    parameter int unsigned SEEK_CYCLES    = 4,
    parameter int unsigned PROTECT_BLOCKS = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    hd_block_ctrl_if.slave  bus
);
    localparam int unsigned WCW = $clog2(BLOCK_WORDS);
    localparam int unsigned BW  = ADDR_WIDTH - WCW;
    localparam int unsigned SCW = (SEEK_CYCLES > 1) ? $clog2(SEEK_CYCLES) : 1;
    localparam logic [WCW-1:0] LAST_WORD = WCW'(BLOCK_WORDS - 1);
    localparam logic [SCW-1:0] LAST_SEEK = SCW'(SEEK_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SEEK, READ, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         blk_q;
    logic                  write_q;
    logic [WCW-1:0]        word_cnt_q;
    logic [SCW-1:0]        seek_cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;
    logic                  accept;
    logic                  rd_issue;
    logic                  wr_beat;
    logic                  mem_we;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // READ issues one array read per cycle until the last word has been
    // issued; the cycle in which that word is presented (rd_last_q) issues
    // nothing, so DONE follows the rd_last cycle.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        rd_issue = 1'b0;
        wr_beat  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    state_d = SEEK;
                end
            end
            SEEK: begin
                if (seek_cnt_q == LAST_SEEK) state_d = write_q ? WRITE : READ;
            end
            READ: begin
                if (rd_last_q) state_d  = DONE;
                else           rd_issue = 1'b1;
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    wr_beat = 1'b1;
                    if (word_cnt_q == LAST_WORD) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_q      <= '0;
            write_q    <= 1'b0;
            word_cnt_q <= '0;
            seek_cnt_q <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            if (accept) begin
                blk_q   <= bus.req_block;
                write_q <= bus.req_write;
            end
            if (state_q == SEEK)
                seek_cnt_q <= (seek_cnt_q == LAST_SEEK) ? '0 : seek_cnt_q + 1'b1;
            if (rd_issue || wr_beat) word_cnt_q <= word_cnt_q + 1'b1;
            else if (state_q == DONE) word_cnt_q <= '0;
            // Synchronous array read: word presented one cycle after issue.
            if (rd_issue) rd_data_q <= mem[{blk_q, word_cnt_q}];
            rd_valid_q <= rd_issue;
            rd_last_q  <= rd_issue && (word_cnt_q == LAST_WORD);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[{blk_q, word_cnt_q}] <= bus.wr_data;
    end

`ifdef HD_WRITE_PROTECT_EN
    logic prot_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      prot_q <= 1'b0;
        else if (accept) prot_q <= bus.req_write && (32'(bus.req_block) < PROTECT_BLOCKS);
    end

    // Protected writes still consume every word; only the array update is dropped.
    assign mem_we  = wr_beat && !prot_q;
    assign bus.err = (state_q == DONE) && prot_q;
`else
    assign mem_we  = wr_beat;
    assign bus.err = 1'b0;
`endif

    assign bus.req_ready = (state_q == IDLE);
    assign bus.wr_ready  = (state_q == WRITE);
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_last   = rd_last_q;
endmodule

// File: tb/tb_hd_block_ctrl.sv
// tb_hd_block_ctrl
//   Self-checking bench for hd_block_ctrl. A reference array (model) tracks
//   every word the bench writes; read requests push the expected words into a
//   queue which is drained as rd_valid words arrive. Builds with or without
//   HD_WRITE_PROTECT_EN.
module tb_hd_block_ctrl;
    localparam int unsigned DW     = 32;
    localparam int unsigned AW     = 9;
    localparam int unsigned BWORDS = 16;
    localparam int unsigned SEEK   = 4;
    localparam int unsigned PROT   = 4;
    localparam int unsigned WCW    = $clog2(BWORDS);
    localparam int unsigned BLK_W  = AW - WCW;
    localparam int unsigned TMO    = 200;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    hd_block_ctrl_if #(.DATA_WIDTH(DW), .BLOCK_W(BLK_W)) bus ();

    hd_block_ctrl #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .BLOCK_WORDS   (BWORDS),
        .SEEK_CYCLES   (SEEK),
        .PROTECT_BLOCKS(PROT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DW-1:0] model [2**AW];
    logic [DW-1:0] exp_q [$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic issue_req(input logic wr, input logic [BLK_W-1:0] blk, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL req_ready_wait: got 0, required 1");
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_block = blk;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Loop index i counts edges since the accept edge (sampled #1 later).
    task automatic run_write(input logic [BLK_W-1:0] blk, input logic [DW-1:0] base,
                             input bit inc, input bit toggle);
        bit ok;
        bit prot = 1'b0;
        bit seen_ready = 1'b0;
        int unsigned n = 0, ready_cnt = 0, done_cnt = 0, err_cnt = 0;
        int unsigned first_ready = 0, done_at = 0;
`ifdef HD_WRITE_PROTECT_EN
        prot = (int'(blk) < int'(PROT));
`endif
        bus.wr_valid = 1'b0;
        issue_req(1'b1, blk, ok);
        if (!ok) return;
        for (int i = 0; i < TMO; i++) begin
            if (bus.done) begin
                done_cnt++;
                if (bus.err) err_cnt++;
                if (done_cnt == 1) done_at = i;
            end
            if (done_cnt > 0 && !bus.done) break;
            bus.wr_valid = toggle ? ((i % 2) == 0) : 1'b1;
            bus.wr_data  = base + (inc ? DW'(n) : '0);
            if (bus.wr_ready) begin
                ready_cnt++;
                if (!seen_ready) begin
                    seen_ready  = 1'b1;
                    first_ready = i;
                end
                if (bus.wr_valid) begin
                    if (!prot) model[{blk, n[WCW-1:0]}] = bus.wr_data;
                    n++;
                end
            end
            @(posedge clk); #1;
        end
        bus.wr_valid = 1'b0;
        vectors++;
        if (first_ready != SEEK) begin
            miscompares++;
            $display("FAIL wr_first_ready blk %0d: got %0d, required %0d", blk, first_ready, SEEK);
        end
        vectors++;
        if (ready_cnt != (toggle ? 2 * BWORDS - 1 : BWORDS)) begin
            miscompares++;
            $display("FAIL wr_ready_cycles blk %0d: got %0d, required %0d", blk, ready_cnt,
                     toggle ? 2 * BWORDS - 1 : BWORDS);
        end
        vectors++;
        if (n != BWORDS) begin
            miscompares++;
            $display("FAIL wr_words blk %0d: got %0d, required %0d", blk, n, BWORDS);
        end
        vectors++;
        if (done_cnt != 1) begin
            miscompares++;
            $display("FAIL wr_done_count blk %0d: got %0d, required 1", blk, done_cnt);
        end
        vectors++;
        if (done_at != SEEK + ready_cnt) begin
            miscompares++;
            $display("FAIL wr_done_time blk %0d: got %0d, required %0d", blk, done_at, SEEK + ready_cnt);
        end
        vectors++;
        if (err_cnt != (prot ? 1 : 0)) begin
            miscompares++;
            $display("FAIL wr_err blk %0d: got %0d, required %0d", blk, err_cnt, prot ? 1 : 0);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_idle_after blk %0d: got busy %b ready %b, required 0 1", blk,
                     bus.busy, bus.req_ready);
        end
    endtask

    // learn=1 records the block into the model instead of comparing it.
    // abort_at>=0 pulls rst_n low right after that word index is seen.
    task automatic run_read(input logic [BLK_W-1:0] blk, input int abort_at, input bit learn);
        bit ok;
        int got = 0, first_at = -1, last_at = -1, done_cnt = 0, done_at = -1, stray = 0;
        logic [DW-1:0] exp_w;
        exp_q.delete();
        if (!learn)
            for (int k = 0; k < int'(BWORDS); k++) exp_q.push_back(model[{blk, k[WCW-1:0]}]);
        issue_req(1'b0, blk, ok);
        if (!ok) return;
        for (int i = 0; i < TMO; i++) begin
            if (bus.rd_valid) begin
                if (got == 0) first_at = i;
                if (learn) begin
                    model[{blk, got[WCW-1:0]}] = bus.rd_data;
                end else if (exp_q.size() == 0) begin
                    stray++;
                end else begin
                    exp_w = exp_q.pop_front();
                    vectors++;
                    if (bus.rd_data !== exp_w) begin
                        miscompares++;
                        $display("FAIL rd_data blk %0d word %0d: got %h, required %h", blk, got,
                                 bus.rd_data, exp_w);
                    end
                end
                vectors++;
                if (bus.rd_last !== (got == int'(BWORDS) - 1)) begin
                    miscompares++;
                    $display("FAIL rd_last blk %0d word %0d: got %b, required %b", blk, got,
                             bus.rd_last, got == int'(BWORDS) - 1);
                end
                if (bus.rd_last) last_at = i;
                if (got == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    vectors++;
                    if (bus.rd_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.busy !== 1'b0 ||
                        bus.done !== 1'b0 || bus.rd_data !== '0) begin
                        miscompares++;
                        $display("FAIL abort_reset: got valid %b ready %b busy %b done %b data %h, required 0 1 0 0 0",
                                 bus.rd_valid, bus.req_ready, bus.busy, bus.done, bus.rd_data);
                    end
                    repeat (2) @(posedge clk);
                    @(negedge clk);
                    rst_n = 1'b1;
                    for (int j = 0; j < 30; j++) begin
                        @(posedge clk); #1;
                        if (bus.done || bus.rd_valid || bus.busy) stray++;
                    end
                    vectors++;
                    if (stray != 0) begin
                        miscompares++;
                        $display("FAIL abort_quiet: got %0d active cycles, required 0", stray);
                    end
                    exp_q.delete();
                    return;
                end
                got++;
            end
            if (bus.done) begin
                done_cnt++;
                done_at = i;
                if (bus.err) stray++;
            end
            if (done_cnt > 0 && !bus.done) break;
            @(posedge clk); #1;
        end
        vectors++;
        if (first_at != int'(SEEK) + 1) begin
            miscompares++;
            $display("FAIL rd_latency blk %0d: got %0d, required %0d", blk, first_at, SEEK + 1);
        end
        vectors++;
        if (got != int'(BWORDS) || exp_q.size() != 0 || stray != 0) begin
            miscompares++;
            $display("FAIL rd_count blk %0d: got %0d words left %0d stray %0d, required %0d 0 0",
                     blk, got, exp_q.size(), stray, BWORDS);
        end
        vectors++;
        if (last_at != first_at + int'(BWORDS) - 1) begin
            miscompares++;
            $display("FAIL rd_last_time blk %0d: got %0d, required %0d", blk, last_at,
                     first_at + int'(BWORDS) - 1);
        end
        vectors++;
        if (done_cnt != 1 || done_at != last_at + 1) begin
            miscompares++;
            $display("FAIL rd_done blk %0d: got count %0d at %0d, required 1 at %0d", blk,
                     done_cnt, done_at, last_at + 1);
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_block = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        rst_n         = 1'b0;
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || bus.wr_ready !== 1'b0 ||
            bus.rd_valid !== 1'b0 || bus.rd_last !== 1'b0 || bus.done !== 1'b0 ||
            bus.err !== 1'b0 || bus.rd_data !== '0) begin
            miscompares++;
            $display("FAIL reset_values: got ready %b busy %b wr_ready %b rd_valid %b last %b done %b err %b data %h, required 1 0 0 0 0 0 0 0",
                     bus.req_ready, bus.busy, bus.wr_ready, bus.rd_valid, bus.rd_last,
                     bus.done, bus.err, bus.rd_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got ready %b busy %b, required 1 0", bus.req_ready, bus.busy);
        end
    endtask

    task automatic test_write_read();
        run_write(BLK_W'(0), 32'h0000_A000, 1'b1, 1'b0);
        run_write(BLK_W'(5), 32'h0000_0100, 1'b1, 1'b0);
        run_read(BLK_W'(5), -1, 1'b0);
    endtask

    task automatic test_last_block();
        run_write(BLK_W'(2**BLK_W - 1), 32'h0000_3100, 1'b1, 1'b1);
        run_read(BLK_W'(2**BLK_W - 1), -1, 1'b0);
        run_read(BLK_W'(0), -1, 1'b0);
    endtask

    task automatic test_reset_mid_read();
        run_read(BLK_W'(5), 7, 1'b0);
        run_read(BLK_W'(5), -1, 1'b0);
    endtask

    // req_valid stays high across a whole read; the second read of the same
    // block must be accepted on the edge closing the IDLE cycle after done.
    task automatic test_back_to_back();
        int got = 0, dones = 0, d1 = -1, viol = 0, stray = 0;
        bit ended = 1'b0;
        logic [DW-1:0] exp_w;
        exp_q.delete();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < int'(BWORDS); k++) exp_q.push_back(model[{BLK_W'(5), k[WCW-1:0]}]);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_block = BLK_W'(5);
        @(posedge clk); #1;
        for (int i = 0; i < 2 * int'(TMO); i++) begin
            if (bus.busy && bus.req_ready) viol++;
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    stray++;
                end else begin
                    exp_w = exp_q.pop_front();
                    vectors++;
                    if (bus.rd_data !== exp_w) begin
                        miscompares++;
                        $display("FAIL b2b_data word %0d: got %h, required %h", got, bus.rd_data, exp_w);
                    end
                end
                got++;
            end
            if (bus.done) begin
                dones++;
                if (dones == 1) d1 = i;
            end
            if (dones == 1 && i == d1 + 1) begin
                vectors++;
                if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_idle: got ready %b busy %b, required 1 0", bus.req_ready, bus.busy);
                end
            end
            if (dones == 1 && i == d1 + 2) begin
                vectors++;
                if (bus.busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_accept: got busy %b, required 1", bus.busy);
                end
                bus.req_valid = 1'b0;
            end
            if (dones == 2 && !bus.done) begin
                ended = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        vectors++;
        if (!ended || dones != 2 || got != 2 * int'(BWORDS) || exp_q.size() != 0 ||
            viol != 0 || stray != 0) begin
            miscompares++;
            $display("FAIL b2b_summary: got dones %0d words %0d left %0d viol %0d stray %0d, required 2 %0d 0 0 0",
                     dones, got, exp_q.size(), viol, stray, 2 * BWORDS);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_protect();
`ifdef HD_WRITE_PROTECT_EN
        run_read(BLK_W'(2), -1, 1'b1);
`endif
        run_write(BLK_W'(2), 32'h0000_DEAD, 1'b0, 1'b0);
        run_read(BLK_W'(2), -1, 1'b0);
        run_write(BLK_W'(PROT), 32'h0000_4400, 1'b1, 1'b0);
        run_read(BLK_W'(PROT), -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_last_block();
        test_reset_mid_read();
        test_back_to_back();
        test_protect();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
